// File: rtl/rtc_calendar_bcd_pkg.sv
// Shared field codes, reset constants and BCD calendar helpers for the RTC.
package rtc_pkg;

  typedef enum logic [2:0] {
    SEL_FRAC  = 3'd0,
    SEL_SEC   = 3'd1,
    SEL_MIN   = 3'd2,
    SEL_HOUR  = 3'd3,
    SEL_DAY   = 3'd4,
    SEL_MONTH = 3'd5,
    SEL_YEAR  = 3'd6,
    SEL_NONE  = 3'd7
  } sel_e;

  localparam logic [15:0] RST_YEAR  = 16'h2000;
  localparam logic [4:0]  RST_MONTH = 5'h01;
  localparam logic [5:0]  RST_DAY   = 6'h01;

  function automatic logic bcd_valid(input logic [3:0] n);
    return n <= 4'd9;
  endfunction

  function automatic logic bcd_div4(input logic [7:0] p);
    if (!p[4]) return (p[3:0] == 4'd0) || (p[3:0] == 4'd4) || (p[3:0] == 4'd8);
    else       return (p[3:0] == 4'd2) || (p[3:0] == 4'd6);
  endfunction

  // A low pair of 00 means a century year, which is leap only when divisible by 400.
  function automatic logic bcd_is_leap(input logic [15:0] y);
    return (y[7:0] == 8'h00) ? bcd_div4(y[15:8]) : bcd_div4(y[7:0]);
  endfunction

  function automatic logic [7:0] bcd_dim(input logic [7:0] m, input logic leap);
    case (m)
      8'h02:                      return leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i+:4] >= 4'd9) r[4*i+:4] = 4'd0;
        else begin
          r[4*i+:4] = r[4*i+:4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [15:0] r;
    logic        b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (b) begin
        if (r[4*i+:4] == 4'd0) r[4*i+:4] = 4'd9;
        else begin
          r[4*i+:4] = r[4*i+:4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rtc_calendar_bcd_wrap_counter.sv
// Min/max BCD field with load, clear, step and wrap; carry flags a wrap on increment.
module bcd_wrap_counter
  import rtc_pkg::*;
#(
  parameter int          W   = 7,
  parameter logic [15:0] MIN = 16'h0000,
  parameter logic [15:0] MAX = 16'h0059
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  input  logic         i_clr,
  input  logic         i_en_inc,
  input  logic         i_en_dec,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_d,
  output logic         o_carry
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_d;
  logic [15:0]  w_p1;
  logic [15:0]  w_m1;
  logic         w_inc;
  logic         w_dec;

  assign w_p1  = bcd_inc(16'(r_q));
  assign w_m1  = bcd_dec(16'(r_q));
  assign w_inc = i_en_inc & ~i_en_dec & ~i_clr & ~i_ld;
  assign w_dec = i_en_dec & ~i_en_inc & ~i_clr & ~i_ld;

  always_comb begin
    w_d = r_q;
    if (i_ld)       w_d = i_ld_val;
    else if (i_clr) w_d = MIN[W-1:0];
    else if (w_inc) w_d = (r_q == MAX[W-1:0]) ? MIN[W-1:0] : w_p1[W-1:0];
    else if (w_dec) w_d = (r_q == MIN[W-1:0]) ? MAX[W-1:0] : w_m1[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= MIN[W-1:0];
    else        r_q <= w_d;
  end

  assign o_q     = r_q;
  assign o_d     = w_d;
  assign o_carry = w_inc & (r_q == MAX[W-1:0]);

endmodule

// File: rtl/rtc_calendar_bcd.sv
// BCD real-time clock/calendar: prescaled tick, carry chain, per-field adjust,
// validated bulk load and once-per-second alarm compare.
module rtc_calendar_bcd
  import rtc_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int FRAC_DIGITS = 2,
  parameter bit HOUR_12     = 1'b0
)(
  input  logic        CLOCK_50,
  input  logic        rst_n,
  input  logic        run,
  input  logic [2:0]  sel,
  input  logic        inc,
  input  logic        dec,
  input  logic        clr,
  input  logic        ld_valid,
  input  logic [55:0] ld_time,
  output logic        ld_err,
  input  logic        alm_en,
  input  logic [23:0] alm_time,
  output logic [((FRAC_DIGITS > 0) ? 4*FRAC_DIGITS : 1)-1:0] frac,
  output logic [6:0]  second,
  output logic [6:0]  minute,
  output logic [5:0]  hour,
  output logic        pm,
  output logic [5:0]  day,
  output logic [4:0]  month,
  output logic [15:0] year,
  output logic        tick_1hz,
  output logic        alarm
);

  localparam int FW      = (FRAC_DIGITS > 0) ? 4*FRAC_DIGITS : 1;
  localparam int PRE_DIV = CLK_HZ / (10**FRAC_DIGITS);
  localparam int PW      = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [15:0] FRAC_MAX = (FRAC_DIGITS == 3) ? 16'h0999 :
                                     (FRAC_DIGITS == 2) ? 16'h0099 : 16'h0009;

  if (FRAC_DIGITS < 0 || FRAC_DIGITS > 3 || (CLK_HZ % (10**FRAC_DIGITS)) != 0) begin : g_bad_cfg
    $error("rtc_calendar_bcd: FRAC_DIGITS must be 0..3 and divide CLK_HZ by 10**FRAC_DIGITS");
  end

  logic [PW-1:0] r_pre;
  logic [5:0]    r_hour, w_hour_n;
  logic          r_pm, w_pm_n;
  logic [5:0]    r_day, w_day_n;
  logic [4:0]    r_month, w_mon_n;
  logic [15:0]   r_year, w_year_n;
  logic          r_tick_1hz, r_alarm, r_ld_err;
  logic          w_tick, w_rt, w_adj, w_ai, w_ad, w_ac;
  logic          w_sel_frac, w_sel_sec, w_sel_min, w_sel_hour, w_sel_day, w_sel_mon, w_sel_year;
  logic          w_c_frac, w_c_sec, w_c_min, w_c_hour, w_c_day, w_c_mon;
  logic [6:0]    w_sec_d, w_min_d;
  logic [15:0]   w_h_p1, w_h_m1, w_d_p1, w_d_m1, w_m_p1, w_m_m1, w_y_p1, w_y_m1;
  logic [7:0]    w_dim_cur, w_dim_n, w_ld_hr, w_ld_dim;
  logic [55:0]   w_ld_chk;
  logic          w_nib_ok, w_ld_ok;
  logic [23:0]   w_alm_now;

  // Prescaler: held at zero when stopped so a restart waits a full period.
  assign w_tick = run & (r_pre == PW'(PRE_DIV - 1));

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n)                     r_pre <= '0;
    else if (!run || w_ld_ok || w_tick) r_pre <= '0;
    else                            r_pre <= r_pre + 1'b1;
  end

  // A load strobe (accepted or not) swallows a coincident tick.
  assign w_rt  = w_tick & ~ld_valid;
  assign w_adj = ~run & ~ld_valid;
  assign w_ai  = w_adj & inc & ~dec & ~clr;
  assign w_ad  = w_adj & dec & ~inc & ~clr;
  assign w_ac  = w_adj & clr;

  assign w_sel_frac = (sel == SEL_FRAC);
  assign w_sel_sec  = (sel == SEL_SEC);
  assign w_sel_min  = (sel == SEL_MIN);
  assign w_sel_hour = (sel == SEL_HOUR);
  assign w_sel_day  = (sel == SEL_DAY);
  assign w_sel_mon  = (sel == SEL_MONTH);
  assign w_sel_year = (sel == SEL_YEAR);

  // Load validation; in 12-hour mode bit 23 is pm, not part of the hour digits.
  assign w_ld_hr  = HOUR_12 ? {1'b0, ld_time[22:16]} : ld_time[23:16];
  assign w_ld_chk = {ld_time[55:24], w_ld_hr, ld_time[15:0]};
  assign w_ld_dim = bcd_dim(ld_time[39:32], bcd_is_leap(ld_time[55:40]));

  always_comb begin
    w_nib_ok = 1'b1;
    for (int i = 0; i < 14; i++)
      if (!bcd_valid(w_ld_chk[4*i+:4])) w_nib_ok = 1'b0;
  end

  assign w_ld_ok = ld_valid & w_nib_ok
                 & (ld_time[39:32] >= 8'h01) & (ld_time[39:32] <= 8'h12)
                 & (ld_time[31:24] >= 8'h01) & (ld_time[31:24] <= w_ld_dim)
                 & (ld_time[15:8] <= 8'h59) & (ld_time[7:0] <= 8'h59)
                 & (HOUR_12 ? ((w_ld_hr >= 8'h01) && (w_ld_hr <= 8'h12)) : (w_ld_hr <= 8'h23));

  if (FRAC_DIGITS > 0) begin : g_frac
    logic [FW-1:0] w_frac_d;
    bcd_wrap_counter #(.W(FW), .MIN(16'h0000), .MAX(FRAC_MAX)) u_frac (
      .clk(CLOCK_50), .rst_n(rst_n), .i_ld(w_ld_ok), .i_ld_val('0),
      .i_clr(w_ac & w_sel_frac), .i_en_inc(w_rt | (w_ai & w_sel_frac)),
      .i_en_dec(w_ad & w_sel_frac), .o_q(frac), .o_d(w_frac_d), .o_carry(w_c_frac)
    );
  end else begin : g_nofrac
    assign frac     = '0;
    assign w_c_frac = 1'b1;
  end

  bcd_wrap_counter #(.W(7), .MIN(16'h0000), .MAX(16'h0059)) u_sec (
    .clk(CLOCK_50), .rst_n(rst_n), .i_ld(w_ld_ok), .i_ld_val(ld_time[6:0]),
    .i_clr(w_ac & w_sel_sec), .i_en_inc((w_rt & w_c_frac) | (w_ai & w_sel_sec)),
    .i_en_dec(w_ad & w_sel_sec), .o_q(second), .o_d(w_sec_d), .o_carry(w_c_sec)
  );

  bcd_wrap_counter #(.W(7), .MIN(16'h0000), .MAX(16'h0059)) u_min (
    .clk(CLOCK_50), .rst_n(rst_n), .i_ld(w_ld_ok), .i_ld_val(ld_time[14:8]),
    .i_clr(w_ac & w_sel_min), .i_en_inc((w_rt & w_c_sec) | (w_ai & w_sel_min)),
    .i_en_dec(w_ad & w_sel_min), .o_q(minute), .o_d(w_min_d), .o_carry(w_c_min)
  );

  assign w_h_p1    = bcd_inc({10'd0, r_hour});
  assign w_h_m1    = bcd_dec({10'd0, r_hour});
  assign w_d_p1    = bcd_inc({10'd0, r_day});
  assign w_d_m1    = bcd_dec({10'd0, r_day});
  assign w_m_p1    = bcd_inc({11'd0, r_month});
  assign w_m_m1    = bcd_dec({11'd0, r_month});
  assign w_y_p1    = bcd_inc(r_year);
  assign w_y_m1    = bcd_dec(r_year);
  assign w_dim_cur = bcd_dim({3'd0, r_month}, bcd_is_leap(r_year));

  always_comb begin
    w_hour_n = r_hour;
    w_pm_n   = r_pm;
    w_day_n  = r_day;
    w_mon_n  = r_month;
    w_year_n = r_year;
    w_c_hour = 1'b0;
    w_c_day  = 1'b0;
    w_c_mon  = 1'b0;
    w_dim_n  = w_dim_cur;
    if (w_ld_ok) begin
      w_hour_n = w_ld_hr[5:0];
      w_pm_n   = HOUR_12 & ld_time[23];
      w_day_n  = ld_time[29:24];
      w_mon_n  = ld_time[36:32];
      w_year_n = ld_time[55:40];
    end else begin
      // 12-hour sequence 12,01..11 with pm flipping at 11->12; midnight is 11 PM -> 12 AM.
      if (w_ac & w_sel_hour) begin
        w_hour_n = HOUR_12 ? 6'h12 : 6'h00;
        w_pm_n   = 1'b0;
      end else if ((w_rt & w_c_min) | (w_ai & w_sel_hour)) begin
        if (HOUR_12) begin
          if (r_hour == 6'h12) w_hour_n = 6'h01;
          else begin
            w_hour_n = w_h_p1[5:0];
            if (r_hour == 6'h11) begin
              w_pm_n   = ~r_pm;
              w_c_hour = r_pm;
            end
          end
        end else if (r_hour == 6'h23) begin
          w_hour_n = 6'h00;
          w_c_hour = 1'b1;
        end else w_hour_n = w_h_p1[5:0];
      end else if (w_ad & w_sel_hour) begin
        if (HOUR_12) begin
          if (r_hour == 6'h01) w_hour_n = 6'h12;
          else begin
            w_hour_n = w_h_m1[5:0];
            if (r_hour == 6'h12) w_pm_n = ~r_pm;
          end
        end else w_hour_n = (r_hour == 6'h00) ? 6'h23 : w_h_m1[5:0];
      end

      if (w_ac & w_sel_day) w_day_n = 6'h01;
      else if ((w_rt & w_c_hour) | (w_ai & w_sel_day)) begin
        if ({2'b00, r_day} >= w_dim_cur) begin
          w_day_n = 6'h01;
          w_c_day = 1'b1;
        end else w_day_n = w_d_p1[5:0];
      end else if (w_ad & w_sel_day)
        w_day_n = (r_day == 6'h01) ? w_dim_cur[5:0] : w_d_m1[5:0];

      if (w_ac & w_sel_mon) w_mon_n = 5'h01;
      else if ((w_rt & w_c_day) | (w_ai & w_sel_mon)) begin
        if (r_month == 5'h12) begin
          w_mon_n = 5'h01;
          w_c_mon = 1'b1;
        end else w_mon_n = w_m_p1[4:0];
      end else if (w_ad & w_sel_mon)
        w_mon_n = (r_month == 5'h01) ? 5'h12 : w_m_m1[4:0];

      if (w_ac & w_sel_year) w_year_n = 16'h0000;
      else if ((w_rt & w_c_mon) | (w_ai & w_sel_year)) w_year_n = w_y_p1;
      else if (w_ad & w_sel_year) w_year_n = w_y_m1;

      // Clamp the day whenever the new month/year leaves it past month end.
      w_dim_n = bcd_dim({3'd0, w_mon_n}, bcd_is_leap(w_year_n));
      if ({2'b00, w_day_n} > w_dim_n) w_day_n = w_dim_n[5:0];
    end
  end

  assign w_alm_now = {w_pm_n, 1'b0, w_hour_n, 1'b0, w_min_d, 1'b0, w_sec_d};

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_hour     <= HOUR_12 ? 6'h12 : 6'h00;
      r_pm       <= 1'b0;
      r_day      <= RST_DAY;
      r_month    <= RST_MONTH;
      r_year     <= RST_YEAR;
      r_tick_1hz <= 1'b0;
      r_alarm    <= 1'b0;
      r_ld_err   <= 1'b0;
    end else begin
      r_hour     <= w_hour_n;
      r_pm       <= w_pm_n;
      r_day      <= w_day_n;
      r_month    <= w_mon_n;
      r_year     <= w_year_n;
      r_tick_1hz <= w_rt & w_c_frac;
      r_alarm    <= w_rt & w_c_frac & alm_en & (w_alm_now == alm_time);
      r_ld_err   <= ld_valid & ~w_ld_ok;
    end
  end

  assign hour     = r_hour;
  assign pm       = r_pm;
  assign day      = r_day;
  assign month    = r_month;
  assign year     = r_year;
  assign tick_1hz = r_tick_1hz;
  assign alarm    = r_alarm;
  assign ld_err   = r_ld_err;

endmodule

// File: doc/rtc_calendar_bcd.md
# rtc_calendar_bcd

Synchronous, parametrised BCD real-time clock/calendar for the DE2 digital clock. It keeps fractional seconds, seconds, minutes, hours, day, month and 4-digit year, with Gregorian leap-year handling. It supports per-field adjust, validated bulk load and a once-per-second alarm compare. All counters run on `CLOCK_50` with a clock-enable tick, so there are no derived or ripple clocks. It feeds the display mux/decoder directly.

## Interface
- `CLK_HZ`, 50_000_000, input clock frequency.
- `FRAC_DIGITS`, 2, number of fractional-second BCD digits, 0..3. `CLK_HZ` must be divisible by 10^FRAC_DIGITS; the design fails elaboration otherwise.
- `HOUR_12`, 0, 1 selects 12-hour mode with `pm`.
- `CLOCK_50` in 1: system clock. All logic is on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `run` in 1: 1 = time advances; 0 = adjust mode.
- `sel` in 3: adjust field. 0 = frac, 1 = sec, 2 = min, 3 = hour, 4 = day, 5 = month, 6 = year, 7 = none.
- `inc`, `dec`, `clr` in 1 each: single-cycle adjust strobes.
- `ld_valid` in 1: load strobe.
- `ld_time` in 56: BCD {year[55:40], month[39:32], day[31:24], hour[23:16], min[15:8], sec[7:0]}. In 12-hour mode, hour bit 23 carries `pm`.
- `ld_err` out 1: one-cycle pulse when a load is rejected.
- `alm_en` in 1: alarm enable.
- `alm_time` in 24: BCD hh:mm:ss. In 12-hour mode, bit 23 carries `pm`.
- `frac` out max(1,4·FRAC_DIGITS): BCD fractional seconds. Tied to 0 when FRAC_DIGITS = 0.
- `second`, `minute` out 7 each: BCD.
- `hour` out 6: BCD.
- `pm` out 1: 0 in 24-hour mode.
- `day` out 6, `month` out 5: BCD.
- `year` out 16: BCD.
- `tick_1hz` out 1: pulse.
- `alarm` out 1: pulse.

## Operation
- **Reset values:** 2000-01-01, time 00:00:00, frac 0, `pm` 0. In 12-hour mode the reset hour is 12. `tick_1hz`, `alarm` and `ld_err` reset to 0.
- **Prescaler:** counts 0..CLK_HZ/10^FRAC_DIGITS−1. On the terminal count it produces a one-cycle `tick`. The prescaler is held at 0 while `run` = 0.
- **Run mode carry chain (all on the same `tick`):**
  - frac wraps at all-9s;
  - sec wraps 59→00;
  - min wraps 59→00;
  - hour wraps 23→00; in 12-hour mode the sequence is 12,01..11, with `pm` toggling on 11→12;
  - day wraps from days-in-month (dim) to 01;
  - month wraps 12→01;
  - year wraps 9999→0000.
- **Leap rule:** leap iff the year is divisible by 4 and not by 100, or is divisible by 400. Evaluate it in BCD:
  - two-digit pair P is divisible by 4 iff (tens even and ones ∈ {0,4,8}) or (tens odd and ones ∈ {2,6});
  - when the low pair is 00, use the high pair instead.
- **Adjust (`run` = 0):**
  - `inc`/`dec` step the selected field within its range and wrap without carrying.
  - `clr` sets the field to its minimum: 0 for frac/sec/min; hour 00, or 12 with `pm` = 0 in 12-hour mode; day 01; month 01; year 0000.
  - Priority: `clr` > `inc`/`dec`. `inc` and `dec` together is a no-op.
  - A strobe with `sel` = 7 does nothing.
  - In run mode the strobes are ignored.
- **Day clamp:** after any month or year change (adjust, or a run-mode carry) that leaves day > dim, day is clamped to dim in the same cycle. Example: 03-31 with `dec` on month gives 02-29 or 02-28.
- **Load:**
  - Accepted in either mode and has top priority.
  - It is valid only if every nibble is ≤ 9, month is 01..12, day is 01..dim(month, year), min/sec ≤ 59, and hour ≤ 23 (24-hour) or 01..12 (12-hour).
  - Valid load: all fields are written, and frac and the prescaler are cleared.
  - Invalid load: no state change and `ld_err` pulses.
- **Alarm:** pulses when a run-mode tick causes a second change and the new {hour, min, sec}, plus `pm` in 12-hour mode, equals `alm_time` while `alm_en` = 1. Loads and adjusts never raise `alarm`.

## Timing
- All outputs are registered.
- Fields update on the clock edge after the cycle where `tick` is high. `tick_1hz` and `alarm` are high during the same cycle in which the new second value is visible.
- Adjust strobes and loads take effect on the next edge. `ld_err` is high in the cycle following the rejected `ld_valid`.
- An adjust or load in the same cycle as a tick takes priority, and that tick is discarded.
- A load coincident with a tick gives the loaded values exactly, with frac = 0.
- `run` 0→1: the first tick occurs a full prescaler period later.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronously). Release is synchronous to the next edge.

## Structure
- **Package `rtc_pkg`:**
  - `sel` field codes;
  - reset-date constants;
  - functions `bcd_is_leap(year)`, `bcd_dim(month, leap)` and `bcd_valid(nibble)`.
- **Sub-module `bcd_wrap_counter`:** parametrised min/max BCD field with `en_inc`, `en_dec`, `clr` and `carry` out. Instantiate it for frac, sec and min. Hour, day and month use custom logic because of 12-hour mode and the dim/clamp rules.

## Test plan
- FRAC_DIGITS = 2, CLK_HZ = 1000, load 1999-12-31 23:59:59, run 100 ticks -> 2000-01-01 00:00:00, frac 00, one `tick_1hz`.
- Roll past 02-28 23:59:59 -> 02-29 in 2000 and 2024, 03-01 in 1900 and 2023.
- Adjust month `dec` from 2023-03-31 -> 02-28. Adjust `inc` on sec at 59 -> 00 with minute unchanged.
- Load 2023-02-30 00:00:00 and hour 0x1A -> `ld_err` pulse, all outputs unchanged.
- HOUR_12 = 1, from 11:59:59 AM -> 12:00:00 with `pm` = 1. Alarm at 12:00:00 PM with `alm_en` -> exactly one `alarm` cycle.
- Assert `rst_n` low mid-carry at 23:59:59.99 -> immediate reset values, no `alarm`.
